cla_pipe_addsub: RTL

//  Parametrised, pipelined carry-lookahead add/subtract unit. It succeeds the fixed 16-bit ripple-of-CLA4 adder.

---
 rtl/cla_pipe_addsub.sv | 115 +++++++++++
 1 files changed

// File: rtl/cla_pipe_addsub.sv
// cla_pipe_addsub: pipelined carry-lookahead add/subtract unit with valid/ready streaming
module cla_pipe_addsub #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4,
  parameter int BLOCK  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_s,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);
  localparam int SW = WIDTH / STAGES;
  localparam int NG = SW / BLOCK;
  localparam int L  = STAGES - 1;

  // One slice: BLOCK-bit groups with sum-of-products lookahead carries, groups rippling.
  function automatic logic [SW:0] slice_add(input logic [SW-1:0] a, input logic [SW-1:0] b,
                                            input logic ci);
    logic [SW-1:0] p, g, s;
    logic [BLOCK:0] c;
    logic gc, acc, pp;
    p  = a ^ b;
    g  = a & b;
    s  = '0;
    gc = ci;
    for (int j = 0; j < NG; j++) begin
      for (int i = 0; i <= BLOCK; i++) begin
        acc = 1'b0;
        pp  = 1'b1;
        for (int m = i - 1; m >= 0; m--) begin
          acc = acc | (pp & g[j*BLOCK+m]);
          pp  = pp & p[j*BLOCK+m];
        end
        c[i] = acc | (pp & gc);
      end
      for (int i = 0; i < BLOCK; i++) s[j*BLOCK+i] = p[j*BLOCK+i] ^ c[i];
      gc = c[BLOCK];
    end
    return {gc, s};
  endfunction

  logic             vld_q [STAGES];
  logic             c_q   [STAGES];
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] s_q   [STAGES];
  logic [WIDTH-1:0] s_d   [STAGES];
  logic [SW:0]      r     [STAGES];
  logic [STAGES:0]  ld;

  // Load enables ripple back from the consumer; an empty stage always loads so bubbles collapse.
  always_comb begin
    ld[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) ld[k] = ~vld_q[k] | ld[k+1];
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    // Resolve slice k from the registered carry and splice it into the deskewed result.
    always_comb begin
      r[k]   = slice_add(a_q[k][k*SW +: SW], b_q[k][k*SW +: SW], c_q[k]);
      s_d[k] = s_q[k];
      s_d[k][k*SW +: SW] = r[k][SW-1:0];
    end
    if (k == 0) begin : g_first
      // Entry stage captures operands with B pre-inverted and the forced carry for subtract.
      always_ff @(posedge clk or posedge rst)
        if (rst) begin
          vld_q[k] <= 1'b0;
          c_q[k]   <= 1'b0;
          a_q[k]   <= '0;
          b_q[k]   <= '0;
          s_q[k]   <= '0;
        end else if (ld[k]) begin
          vld_q[k] <= in_valid;
          c_q[k]   <= in_sub | in_cin;
          a_q[k]   <= in_a;
          b_q[k]   <= in_sub ? ~in_b : in_b;
          s_q[k]   <= '0;
        end
    end else begin : g_next
      // Later stages take the upstream carry-out and the partial result built so far.
      always_ff @(posedge clk or posedge rst)
        if (rst) begin
          vld_q[k] <= 1'b0;
          c_q[k]   <= 1'b0;
          a_q[k]   <= '0;
          b_q[k]   <= '0;
          s_q[k]   <= '0;
        end else if (ld[k]) begin
          vld_q[k] <= vld_q[k-1];
          c_q[k]   <= r[k-1][SW];
          a_q[k]   <= a_q[k-1];
          b_q[k]   <= b_q[k-1];
          s_q[k]   <= s_d[k-1];
        end
    end
  end

  assign in_ready  = ld[0];
  assign out_valid = vld_q[L];
  assign out_s     = s_d[L];
  assign out_cout  = r[L][SW];
  assign out_ovf   = (a_q[L][WIDTH-1] == b_q[L][WIDTH-1]) && (s_d[L][WIDTH-1] != a_q[L][WIDTH-1]);
  assign out_zero  = vld_q[L] & ~|s_d[L];
endmodule
